rom_bus_arbiter: RTL and testbench
==================================

// Module: rom_bus_arbiter
// PURPOSE
// - Sequences all accesses to the shared 16-bit cartridge SRAM (ROM/SaveRAM/PSRAM image) between SNES bus cycles and MCU requests.
// - SNES side consumes the decoded SRAM address plus hit/writable flags from the address mapper; MCU side is a pulse request / ready handshake.
// - Owns SRAM strobe timing, byte-lane selection and data-bus drive enable; SNES strictly outranks MCU.
// PARAMETERS
// - RD_CYCLES  4  SRAM read phase length in CLK cycles (>=2); data sampled on last cycle
// - WR_CYCLES  5  SRAM write phase length in CLK cycles (>=3); setup, WE pulse, hold
// PORTS
// - CLK            in   1   system clock; all logic rising-edge
// - RST            in   1   reset: synchronous and active-high
// - snes_rd_strobe in   1   1-cycle pulse: SNES read cycle begins
// - snes_wr_strobe in   1   1-cycle pulse: SNES write data valid
// - snes_addr      in   24  decoded SRAM byte address from mapper
// - snes_hit       in   1   mapper ROM_HIT; strobe ignored when 0
// - snes_writable  in   1   mapper IS_WRITABLE; write strobe ignored when 0
// - snes_wdata     in   8   SNES write data, valid with snes_wr_strobe
// - snes_rdata     out  8   SNES read data, held until next SNES read completes
// - snes_rdata_vld out  1   1-cycle pulse: snes_rdata updated
// - mcu_rrq        in   1   1-cycle pulse: MCU read request
// - mcu_wrq        in   1   1-cycle pulse: MCU write request
// - mcu_addr       in   24  MCU SRAM byte address, captured with request
// - mcu_wdata      in   8   MCU write data, captured with mcu_wrq
// - mcu_rdata      out  8   MCU read data, valid when mcu_rq_rdy pulses
// - mcu_rq_rdy     out  1   1-cycle pulse: MCU request completed
// - ROM_ADDR_OUT   out  23  SRAM word address = addr[23:1]
// - ROM_CE_N/ROM_OE_N/ROM_WE_N/ROM_BHE_N/ROM_BLE_N out 1 each  SRAM strobes, active-low
// - ROM_DQ_OUT     out  16  write data, byte duplicated on both lanes
// - ROM_DQ_OE      out  1   1 = drive ROM_DQ_OUT onto pad
// - ROM_DQ_IN      in   16  SRAM read data from pad
// BEHAVIOUR
// - Reset: state IDLE; all _N strobes 1; ROM_DQ_OE 0; ROM_ADDR_OUT 0; rdata regs 0; vld/rdy 0; both pending slots cleared.
// - Reset mid-operation: strobes deasserted at the reset edge, access abandoned, no vld/rdy pulse, pending dropped.
// - Capture: SNES strobe with hit (and writable for writes) loads snes pending slot {type,addr,data}; a new SNES strobe overwrites an unserviced slot.
// - MCU request loads mcu pending slot; requests while slot busy are ignored; rrq+wrq same cycle -> write.
// - States: IDLE, RD, WR, DONE. IDLE picks snes slot first, else mcu slot, else stays; slot cleared on grant.
// - Grant never preempts an access in flight; SNES strobe during MCU access waits; worst SNES start delay = WR_CYCLES+2.
// - Lane: addr[0]=0 -> BLE_N=0,BHE_N=1; addr[0]=1 -> BHE_N=0,BLE_N=1; byte returned from that lane.
// - RD: CE_N=OE_N=0, lane enable low, for RD_CYCLES cycles; ROM_DQ_IN latched on last RD cycle; then DONE.
// - WR: ROM_DQ_OE=1, CE_N=0, lane low for WR_CYCLES; WE_N=0 only on cycles 1..WR_CYCLES-2; then DONE.
// - DONE (1 cycle): strobes high, DQ_OE 0; pulse snes_rdata_vld (SNES read) or mcu_rq_rdy (any MCU access); SNES writes pulse nothing. -> IDLE.
// - Idle SNES read latency: strobe edge -> snes_rdata_vld = RD_CYCLES+2 cycles.
// - Phase counter: width $clog2(max(RD,WR)+1), reloads on state entry, no wrap.
// - ROM_DQ_OE and WE_N never both active outside WR; OE_N never low while DQ_OE=1.
// STRUCTURE
// - Shared package/include: state encoding, SRAM strobe bundle struct, lane-select function.
// - Sub-module sram_phase_timer: loadable down-counter emitting first/last-cycle flags per phase.
// - Top: two capture slots, arbiter FSM, registered SRAM outputs.
// TESTING
// - Idle SNES read 0x012345, DQ_IN=0xAB00 -> ROM_ADDR_OUT=0x0091A2, BHE_N=0, snes_rdata=0xAB, vld 6 cycles after strobe.
// - SNES write 0xE00000, data 0x5A, writable=1 -> DQ_OUT=0x5A5A, BLE_N=0, WE_N low cycles 1..3; writable=0 -> no CE/WE activity.
// - MCU read running, SNES read strobe 1 cycle later -> MCU finishes with rdy pulse, SNES RD starts next IDLE cycle, vld <= 13 cycles after SNES strobe.
// - SNES and MCU strobes same cycle -> SNES access first, MCU follows; rdy after SNES vld.
// - RST asserted in WR cycle 2 -> WE_N=1, DQ_OE=0 next edge, no rdy; fresh request after reset serviced normally.
// - snes_hit=0 strobe and MCU request while slot busy -> no SRAM activity, no extra rdy pulse.

Source files
------------

// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types for the cartridge SRAM bus arbiter: FSM encoding, SRAM control
// bundle, request slot layout and byte-lane selection.
package rom_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
  } req_slot_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic bhe_n;
    logic ble_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = 6'b111110;

  // Returns {bhe_n, ble_n}: odd byte addresses live on the high lane.
  function automatic logic [1:0] lane_sel(input logic byte_sel);
    return byte_sel ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_phase_timer.sv
// Loadable down-counter timing one SRAM access phase; flags the first and
// last cycle of the phase and parks at zero afterwards.
module sram_phase_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          first,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      first <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/rom_bus_arbiter.sv
// Arbitrates the shared 16-bit cartridge SRAM between SNES bus cycles and MCU
// requests; SNES always wins, accesses in flight are never preempted.
module rom_bus_arbiter
  import rom_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 4,
  parameter int unsigned WR_CYCLES = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        snes_rd_strobe,
  input  logic        snes_wr_strobe,
  input  logic [23:0] snes_addr,
  input  logic        snes_hit,
  input  logic        snes_writable,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_rdata_vld,
  input  logic        mcu_rrq,
  input  logic        mcu_wrq,
  input  logic [23:0] mcu_addr,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_rq_rdy,
  output logic [22:0] ROM_ADDR_OUT,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        ROM_BHE_N,
  output logic        ROM_BLE_N,
  output logic [15:0] ROM_DQ_OUT,
  output logic        ROM_DQ_OE,
  input  logic [15:0] ROM_DQ_IN
);

  localparam int unsigned MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);

  arb_state_t    state;
  req_slot_t     snes_slot, mcu_slot;
  logic [23:0]   act_addr;
  logic [7:0]    act_data;
  logic          act_wr, act_snes;
  logic          grant_snes, grant_mcu, grant_wr;
  logic          tmr_load, tmr_first, tmr_last;
  logic [CW-1:0] tmr_val;
  logic [7:0]    lane_byte;
  sram_ctl_t     ctl;

  assign grant_snes = (state == ST_IDLE) && snes_slot.valid;
  assign grant_mcu  = (state == ST_IDLE) && !snes_slot.valid && mcu_slot.valid;
  assign grant_wr   = grant_snes ? snes_slot.wr : mcu_slot.wr;
  assign tmr_load   = grant_snes || grant_mcu;
  assign tmr_val    = grant_wr ? WR_LOAD : RD_LOAD;
  assign lane_byte  = act_addr[0] ? ROM_DQ_IN[15:8] : ROM_DQ_IN[7:0];

  sram_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .first    (tmr_first),
    .last     (tmr_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      snes_slot  <= '0;
      mcu_slot   <= '0;
      act_addr   <= '0;
      act_data   <= '0;
      act_wr     <= 1'b0;
      act_snes   <= 1'b0;
      snes_rdata <= '0;
      mcu_rdata  <= '0;
    end else begin
      // A fresh SNES strobe in the grant cycle must survive the slot clear.
      if (grant_snes) snes_slot.valid <= 1'b0;
      if (snes_wr_strobe && snes_hit && snes_writable)
        snes_slot <= '{valid: 1'b1, wr: 1'b1, addr: snes_addr, data: snes_wdata};
      else if (snes_rd_strobe && snes_hit)
        snes_slot <= '{valid: 1'b1, wr: 1'b0, addr: snes_addr, data: 8'h00};

      if (grant_mcu)
        mcu_slot.valid <= 1'b0;
      else if (!mcu_slot.valid && (mcu_rrq || mcu_wrq))
        mcu_slot <= '{valid: 1'b1, wr: mcu_wrq, addr: mcu_addr, data: mcu_wdata};

      case (state)
        ST_IDLE: begin
          if (tmr_load) begin
            act_snes <= grant_snes;
            act_wr   <= grant_wr;
            act_addr <= grant_snes ? snes_slot.addr : mcu_slot.addr;
            act_data <= grant_snes ? snes_slot.data : mcu_slot.data;
            state    <= grant_wr ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          if (tmr_last) begin
            if (act_snes) snes_rdata <= lane_byte;
            else          mcu_rdata  <= lane_byte;
            state <= ST_DONE;
          end
        end
        ST_WR: begin
          if (tmr_last) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctl = SRAM_CTL_IDLE;
    if (state == ST_RD || state == ST_WR) begin
      ctl.ce_n = 1'b0;
      {ctl.bhe_n, ctl.ble_n} = lane_sel(act_addr[0]);
      if (state == ST_RD) begin
        ctl.oe_n = 1'b0;
      end else begin
        ctl.dq_oe = 1'b1;
        // WE stays high on the first (setup) and last (hold) write cycles.
        ctl.we_n  = tmr_first || tmr_last;
      end
    end
  end

  assign ROM_CE_N       = ctl.ce_n;
  assign ROM_OE_N       = ctl.oe_n;
  assign ROM_WE_N       = ctl.we_n;
  assign ROM_BHE_N      = ctl.bhe_n;
  assign ROM_BLE_N      = ctl.ble_n;
  assign ROM_DQ_OE      = ctl.dq_oe;
  assign ROM_ADDR_OUT   = act_addr[23:1];
  assign ROM_DQ_OUT     = {act_data, act_data};
  assign snes_rdata_vld = (state == ST_DONE) && act_snes && !act_wr;
  assign mcu_rq_rdy     = (state == ST_DONE) && !act_snes;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed scenarios plus randomized
// SNES/MCU traffic checked against a byte-addressed reference memory.
module tb_rom_bus_arbiter;

  localparam int unsigned RD_CYCLES = 4;
  localparam int unsigned WR_CYCLES = 5;

  logic        CLK = 1'b0;
  logic        RST;
  logic        snes_rd_strobe, snes_wr_strobe, snes_hit, snes_writable;
  logic [23:0] snes_addr;
  logic [7:0]  snes_wdata, snes_rdata;
  logic        snes_rdata_vld;
  logic        mcu_rrq, mcu_wrq, mcu_rq_rdy;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wdata, mcu_rdata;
  logic [22:0] ROM_ADDR_OUT;
  logic        ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE;
  logic [15:0] ROM_DQ_OUT, ROM_DQ_IN;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [0:31];
  logic [15:0] sram [0:15];
  logic        mem_init_req = 1'b0;
  logic        dq_force_en  = 1'b1;
  logic [15:0] dq_force_val = 16'h0000;

  always #5 CLK = ~CLK;

  rom_bus_arbiter #(
    .RD_CYCLES(RD_CYCLES),
    .WR_CYCLES(WR_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST),
    .snes_rd_strobe(snes_rd_strobe), .snes_wr_strobe(snes_wr_strobe),
    .snes_addr(snes_addr), .snes_hit(snes_hit), .snes_writable(snes_writable),
    .snes_wdata(snes_wdata), .snes_rdata(snes_rdata), .snes_rdata_vld(snes_rdata_vld),
    .mcu_rrq(mcu_rrq), .mcu_wrq(mcu_wrq), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rdata(mcu_rdata), .mcu_rq_rdy(mcu_rq_rdy),
    .ROM_ADDR_OUT(ROM_ADDR_OUT), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
    .ROM_WE_N(ROM_WE_N), .ROM_BHE_N(ROM_BHE_N), .ROM_BLE_N(ROM_BLE_N),
    .ROM_DQ_OUT(ROM_DQ_OUT), .ROM_DQ_OE(ROM_DQ_OE), .ROM_DQ_IN(ROM_DQ_IN)
  );

  // Small SRAM model: 16 words, written per lane while WE_N is low.
  assign ROM_DQ_IN = dq_force_en ? dq_force_val :
                     ((!ROM_CE_N && !ROM_OE_N) ? sram[ROM_ADDR_OUT[3:0]] : 16'hDEAD);

  always @(posedge CLK) begin
    if (mem_init_req) begin
      for (int i = 0; i < 16; i++) sram[i] <= {ref_mem[2*i+1], ref_mem[2*i]};
    end else if (!ROM_CE_N && !ROM_WE_N) begin
      if (!ROM_BLE_N) sram[ROM_ADDR_OUT[3:0]][7:0]  <= ROM_DQ_OUT[7:0];
      if (!ROM_BHE_N) sram[ROM_ADDR_OUT[3:0]][15:8] <= ROM_DQ_OUT[15:8];
    end
  end

  task automatic clear_inputs();
    snes_rd_strobe = 1'b0; snes_wr_strobe = 1'b0; snes_hit = 1'b0; snes_writable = 1'b0;
    snes_addr = '0; snes_wdata = '0;
    mcu_rrq = 1'b0; mcu_wrq = 1'b0; mcu_addr = '0; mcu_wdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE} !== 6'b111110) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 111110",
               {ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE});
    end
    checks++;
    if (ROM_ADDR_OUT !== 23'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", ROM_ADDR_OUT);
    end
    checks++;
    if ({snes_rdata, mcu_rdata} !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", snes_rdata, mcu_rdata);
    end
    checks++;
    if ({snes_rdata_vld, mcu_rq_rdy} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses: got %b want 00", {snes_rdata_vld, mcu_rq_rdy});
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ROM_CE_N, ROM_DQ_OE} !== 2'b10) begin
      errors++; $display("FAIL reset_idle_after: got %b want 10", {ROM_CE_N, ROM_DQ_OE});
    end
  endtask

  task automatic test_idle_read();
    int vld_at;
    vld_at = -1;
    dq_force_en = 1'b1; dq_force_val = 16'hAB00;
    snes_addr = 24'h012345; snes_hit = 1'b1; snes_rd_strobe = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      snes_rd_strobe = 1'b0;
      if (k == 2) begin
        checks++;
        if (ROM_ADDR_OUT !== 23'h0091A2) begin
          errors++; $display("FAIL idle_read_addr: got %h want 0091a2", ROM_ADDR_OUT);
        end
        checks++;
        if ({ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE} !== 6'b001010) begin
          errors++;
          $display("FAIL idle_read_strobes: got %b want 001010",
                   {ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE});
        end
      end
      if (snes_rdata_vld === 1'b1 && vld_at < 0) begin
        vld_at = k;
        checks++;
        if (snes_rdata !== 8'hAB) begin
          errors++; $display("FAIL idle_read_data: got %h want ab", snes_rdata);
        end
      end
    end
    checks++;
    if (vld_at != int'(RD_CYCLES + 2)) begin
      errors++; $display("FAIL idle_read_latency: got %0d want %0d", vld_at, RD_CYCLES + 2);
    end
    clear_inputs();
  endtask

  task automatic test_snes_write();
    logic [15:0] we_mask, exp_mask;
    int pulses, ce_low;
    we_mask = '0; exp_mask = '0; pulses = 0; ce_low = 0;
    for (int i = 1; i <= int'(WR_CYCLES) - 2; i++) exp_mask[2 + i] = 1'b1;
    snes_addr = 24'hE00000; snes_wdata = 8'h5A; snes_hit = 1'b1; snes_writable = 1'b1;
    snes_wr_strobe = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      snes_wr_strobe = 1'b0;
      we_mask[k] = ~ROM_WE_N;
      if (snes_rdata_vld === 1'b1 || mcu_rq_rdy === 1'b1) pulses++;
      if (k == 2) begin
        checks++;
        if (ROM_DQ_OUT !== 16'h5A5A) begin
          errors++; $display("FAIL snes_write_dq: got %h want 5a5a", ROM_DQ_OUT);
        end
        checks++;
        if ({ROM_CE_N, ROM_OE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE} !== 5'b01101) begin
          errors++;
          $display("FAIL snes_write_strobes: got %b want 01101",
                   {ROM_CE_N, ROM_OE_N, ROM_BHE_N, ROM_BLE_N, ROM_DQ_OE});
        end
      end
    end
    checks++;
    if (we_mask !== exp_mask) begin
      errors++; $display("FAIL snes_write_we_cycles: got %h want %h", we_mask, exp_mask);
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL snes_write_pulses: got %0d want 0", pulses);
    end
    snes_writable = 1'b0; snes_wr_strobe = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      snes_wr_strobe = 1'b0;
      if (ROM_CE_N !== 1'b1 || ROM_WE_N !== 1'b1) ce_low++;
    end
    checks++;
    if (ce_low != 0) begin
      errors++; $display("FAIL snes_write_protected: got %0d active cycles want 0", ce_low);
    end
    clear_inputs();
  endtask

  task automatic test_mcu_then_snes();
    int rdy_at, vld_at, oe_at;
    rdy_at = -1; vld_at = -1; oe_at = -1;
    dq_force_en = 1'b1; dq_force_val = 16'h1234;
    mcu_addr = 24'h000010; mcu_rrq = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      mcu_rrq = 1'b0;
      snes_rd_strobe = 1'b0;
      if (k == 2) begin
        snes_addr = 24'h000021; snes_hit = 1'b1; snes_rd_strobe = 1'b1;
      end
      if (mcu_rq_rdy === 1'b1 && rdy_at < 0) begin
        rdy_at = k;
        checks++;
        if (mcu_rdata !== 8'h34) begin
          errors++; $display("FAIL mcu_snes_mcu_data: got %h want 34", mcu_rdata);
        end
      end
      if (rdy_at > 0 && k > rdy_at && oe_at < 0 && ROM_OE_N === 1'b0) oe_at = k;
      if (snes_rdata_vld === 1'b1 && vld_at < 0) begin
        vld_at = k;
        checks++;
        if (snes_rdata !== 8'h12) begin
          errors++; $display("FAIL mcu_snes_snes_data: got %h want 12", snes_rdata);
        end
      end
    end
    checks++;
    if (rdy_at != int'(RD_CYCLES + 2)) begin
      errors++; $display("FAIL mcu_snes_rdy_time: got %0d want %0d", rdy_at, RD_CYCLES + 2);
    end
    checks++;
    if (oe_at != rdy_at + 2) begin
      errors++; $display("FAIL mcu_snes_restart: got %0d want %0d", oe_at, rdy_at + 2);
    end
    checks++;
    if (vld_at < 0 || vld_at - 2 > 13 || vld_at <= rdy_at) begin
      errors++; $display("FAIL mcu_snes_vld_delay: got %0d want <=13 after strobe and after rdy", vld_at - 2);
    end
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    int rdy_at, vld_at;
    rdy_at = -1; vld_at = -1;
    dq_force_en = 1'b1; dq_force_val = 16'hC3A5;
    snes_addr = 24'h000003; snes_hit = 1'b1; snes_rd_strobe = 1'b1;
    mcu_addr = 24'h000004; mcu_rrq = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      snes_rd_strobe = 1'b0; mcu_rrq = 1'b0;
      if (snes_rdata_vld === 1'b1 && vld_at < 0) begin
        vld_at = k;
        checks++;
        if (snes_rdata !== 8'hC3) begin
          errors++; $display("FAIL same_cycle_snes_data: got %h want c3", snes_rdata);
        end
      end
      if (mcu_rq_rdy === 1'b1 && rdy_at < 0) begin
        rdy_at = k;
        checks++;
        if (mcu_rdata !== 8'hA5) begin
          errors++; $display("FAIL same_cycle_mcu_data: got %h want a5", mcu_rdata);
        end
      end
    end
    checks++;
    if (vld_at != int'(RD_CYCLES + 2)) begin
      errors++; $display("FAIL same_cycle_vld_time: got %0d want %0d", vld_at, RD_CYCLES + 2);
    end
    checks++;
    if (rdy_at != int'(2 * (RD_CYCLES + 2))) begin
      errors++; $display("FAIL same_cycle_rdy_time: got %0d want %0d", rdy_at, 2 * (RD_CYCLES + 2));
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_write();
    int rdy_cnt, rdy_at;
    rdy_cnt = 0; rdy_at = -1;
    mcu_addr = 24'h000006; mcu_wdata = 8'h77; mcu_wrq = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      mcu_wrq = 1'b0;
      if (mcu_rq_rdy === 1'b1) rdy_cnt++;
      if (k == 4) begin
        checks++;
        if (ROM_WE_N !== 1'b0) begin
          errors++; $display("FAIL rst_mid_we_before: got %b want 0", ROM_WE_N);
        end
        RST = 1'b1;
      end
      if (k == 5) begin
        checks++;
        if ({ROM_CE_N, ROM_WE_N, ROM_DQ_OE} !== 3'b110) begin
          errors++; $display("FAIL rst_mid_strobes: got %b want 110", {ROM_CE_N, ROM_WE_N, ROM_DQ_OE});
        end
        RST = 1'b0;
      end
    end
    checks++;
    if (rdy_cnt != 0) begin
      errors++; $display("FAIL rst_mid_no_rdy: got %0d want 0", rdy_cnt);
    end
    dq_force_en = 1'b1; dq_force_val = 16'h4D00;
    mcu_addr = 24'h000009; mcu_rrq = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      mcu_rrq = 1'b0;
      if (mcu_rq_rdy === 1'b1 && rdy_at < 0) begin
        rdy_at = k;
        checks++;
        if (mcu_rdata !== 8'h4D) begin
          errors++; $display("FAIL rst_mid_fresh_data: got %h want 4d", mcu_rdata);
        end
      end
    end
    checks++;
    if (rdy_at != int'(RD_CYCLES + 2)) begin
      errors++; $display("FAIL rst_mid_fresh_time: got %0d want %0d", rdy_at, RD_CYCLES + 2);
    end
    clear_inputs();
  endtask

  task automatic test_ignored();
    int active, pulses, rdy_cnt, we_low;
    active = 0; pulses = 0; rdy_cnt = 0; we_low = 0;
    snes_addr = 24'h000002; snes_hit = 1'b0; snes_rd_strobe = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      snes_rd_strobe = 1'b0;
      if (ROM_CE_N !== 1'b1) active++;
      if (snes_rdata_vld === 1'b1 || mcu_rq_rdy === 1'b1) pulses++;
    end
    checks++;
    if (active != 0 || pulses != 0) begin
      errors++; $display("FAIL no_hit_ignored: got %0d active/%0d pulses want 0/0", active, pulses);
    end
    snes_hit = 1'b1; snes_rd_strobe = 1'b1;
    mcu_addr = 24'h000008; mcu_rrq = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      snes_rd_strobe = 1'b0; mcu_rrq = 1'b0; mcu_wrq = 1'b0;
      if (k == 1) begin
        mcu_addr = 24'h00000A; mcu_wdata = 8'hEE; mcu_wrq = 1'b1;
      end
      if (mcu_rq_rdy === 1'b1) rdy_cnt++;
      if (ROM_WE_N === 1'b0) we_low++;
    end
    checks++;
    if (rdy_cnt != 1) begin
      errors++; $display("FAIL busy_slot_rdy_count: got %0d want 1", rdy_cnt);
    end
    checks++;
    if (we_low != 0) begin
      errors++; $display("FAIL busy_slot_no_write: got %0d we cycles want 0", we_low);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int unsigned mode;
    logic s_go, m_go, swr, shit, swrt, mwr, exp_vld;
    logic [4:0] sa, ma;
    logic [7:0] sd, md, exp_s, exp_m;
    int vld_n, rdy_n;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'($urandom);
    mem_init_req = 1'b1;
    @(negedge CLK);
    mem_init_req = 1'b0;
    dq_force_en = 1'b0;
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      s_go = (mode != 0); m_go = (mode != 1);
      swr = 1'($urandom); shit = ($urandom_range(0, 7) != 0); swrt = ($urandom_range(0, 7) != 0);
      sa = 5'($urandom); sd = 8'($urandom);
      mwr = 1'($urandom); ma = 5'($urandom); md = 8'($urandom);
      exp_s = '0; exp_m = '0; exp_vld = 1'b0;
      // SNES is served before a simultaneous MCU request.
      if (s_go && shit && (!swr || swrt)) begin
        if (swr) ref_mem[sa] = sd;
        else begin exp_s = ref_mem[sa]; exp_vld = 1'b1; end
      end
      if (m_go) begin
        if (mwr) ref_mem[ma] = md;
        else exp_m = ref_mem[ma];
      end
      snes_addr = {19'h0, sa}; snes_wdata = sd; snes_hit = shit; snes_writable = swrt;
      snes_rd_strobe = s_go && !swr; snes_wr_strobe = s_go && swr;
      mcu_addr = {19'h0, ma}; mcu_wdata = md;
      mcu_rrq = m_go && !mwr; mcu_wrq = m_go && mwr;
      vld_n = 0; rdy_n = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge CLK);
        snes_rd_strobe = 1'b0; snes_wr_strobe = 1'b0; mcu_rrq = 1'b0; mcu_wrq = 1'b0;
        checks++;
        if (ROM_DQ_OE === 1'b1 && ROM_OE_N !== 1'b1) begin
          errors++; $display("FAIL rand_oe_contention: got OE_N=%b DQ_OE=1 want OE_N=1", ROM_OE_N);
        end
        checks++;
        if (ROM_WE_N === 1'b0 && (ROM_DQ_OE !== 1'b1 || ROM_CE_N !== 1'b0)) begin
          errors++; $display("FAIL rand_we_outside_write: got DQ_OE=%b CE_N=%b want 1/0", ROM_DQ_OE, ROM_CE_N);
        end
        if (snes_rdata_vld === 1'b1) begin
          vld_n++;
          checks++;
          if (snes_rdata !== exp_s) begin
            errors++; $display("FAIL rand_snes_data[%0d]: got %h want %h", t, snes_rdata, exp_s);
          end
        end
        if (mcu_rq_rdy === 1'b1) begin
          rdy_n++;
          if (!mwr) begin
            checks++;
            if (mcu_rdata !== exp_m) begin
              errors++; $display("FAIL rand_mcu_data[%0d]: got %h want %h", t, mcu_rdata, exp_m);
            end
          end
        end
      end
      checks++;
      if (vld_n != int'(exp_vld)) begin
        errors++; $display("FAIL rand_vld_count[%0d]: got %0d want %0d", t, vld_n, int'(exp_vld));
      end
      checks++;
      if (rdy_n != int'(m_go)) begin
        errors++; $display("FAIL rand_rdy_count[%0d]: got %0d want %0d", t, rdy_n, int'(m_go));
      end
    end
    clear_inputs();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_idle_read();
    test_snes_write();
    test_mcu_then_snes();
    test_same_cycle();
    test_reset_mid_write();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
